sub_bytes_iter: RTL and testbench
=================================

SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 Parameters SHALL be none; all widths are fixed by AES-128.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 in_valid  input  1  upstream offers in_state.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 in_state  input  128  AES state; byte i = bits [8i+7:8i], i=0..15.
REQ-007 out_valid  output  1  out_state holds a completed SubBytes result.
REQ-008 out_ready  input  1  downstream accepts out_state.
REQ-009 out_state  output  128  substituted state; byte i = S(in byte i).
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Substitution SHALL use the AES forward S-box (FIPS-197), 8-bit in to 8-bit out, combinational, applied to bytes of an internal 128-bit work register.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a clock edge, load work register from in_state, set byte counter cnt=0, go to RUN.
REQ-014 RUN: in_ready=0; each cycle replace the byte(s) selected by cnt with their S-box images, then advance cnt; after the last group, go to DONE.
REQ-015 Without SUBBYTES_PAR4_EN, RUN SHALL process 1 byte per cycle in order 0..15 over exactly 16 cycles; cnt is 4 bits and wraps to 0 on the last byte.
REQ-016 DONE: out_valid=1, out_state = work register, held stable until out_ready=1; on out_valid&&out_ready, go to IDLE.
REQ-017 Latency SHALL be 16 clocks (4 with SUBBYTES_PAR4_EN) from the accepting edge to the edge on which out_valid rises.
REQ-018 in_ready SHALL NOT be asserted in RUN or DONE; in_valid in those states is ignored and input data is not sampled.
REQ-019 A new state SHALL be accepted no earlier than the cycle after the DONE handshake; minimum initiation interval is 18 cycles (6 with PAR4).
REQ-020 out_state SHALL retain its last value after the handshake until the next completion overwrites it.
REQ-021 in_state changing during RUN SHALL NOT affect the result.
REQ-022 out_ready held high while not in DONE SHALL have no effect.

Reset
REQ-023 On rst=1 at a clock edge, in any state including mid-RUN, the FSM SHALL go to IDLE and cnt SHALL reset to 0.
REQ-024 Reset values: in_ready=1 once in IDLE, out_valid=0, busy=0, out_state=128'h0, work register=128'h0.
REQ-025 rst SHALL take priority over in_valid and out_ready on the same edge; a partial result SHALL be discarded and never presented.

Configuration
REQ-026 Macro SUBBYTES_PAR4_EN: when defined, four S-box lookups SHALL operate in parallel, processing bytes 4k..4k+3 in RUN cycle k (k=0..3); cnt is 2 bits and RUN lasts exactly 4 cycles.
REQ-027 When SUBBYTES_PAR4_EN is undefined, exactly one S-box lookup SHALL be instantiated and REQ-015 timing applies; the interface and results are identical in both builds.

Verification
REQ-028 rst, then in_state=128'h0 with in_valid=1 for 1 cycle -> after 16 clocks (4 with PAR4), out_valid=1 and out_state=128'h63636363636363636363636363636363.
REQ-029 in_state=128'h00112233445566778899aabbccddeeff -> out_state=128'h638293c31bfc33f5c4eeacea4bc12816.
REQ-030 out_ready=0 for 10 cycles after completion -> out_valid stays 1, out_state stable, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-031 rst pulsed at RUN cycle 7 -> next cycle in IDLE, out_valid=0, out_state=0; the following input 128'h53 (byte0=0x53, others 0) -> byte0=0xed, others 0x63.
REQ-032 in_valid held high with a new in_state every cycle, out_ready=1 -> exactly one accept per 18 cycles (6 with PAR4); each output matches the S-box image of the state sampled at its accept edge.

Source files
------------

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes over a 128-bit state: one S-box lookup per RUN cycle by default,
// four parallel lookups per cycle when SUBBYTES_PAR4_EN is defined.
module sub_bytes_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Row 0 of the FIPS-197 table sits in the MSBs, so S(b) lives at bit offset 8*(255-b).
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b000} +: 8];
  endfunction

`ifdef SUBBYTES_PAR4_EN
  localparam int unsigned Lanes = 4;
  localparam int unsigned CntW  = 2;
`else
  localparam int unsigned Lanes = 1;
  localparam int unsigned CntW  = 4;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [127:0]      work_q, work_d;
  logic [127:0]      out_q, out_d;
  logic [3:0]        base;

`ifdef SUBBYTES_PAR4_EN
  assign base = {cnt_q, 2'b00};
`else
  assign base = cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned l = 0; l < Lanes; l++) begin
          logic [3:0] idx;
          idx = base + 4'(l);
          work_d[idx*8 +: 8] = sbox(work_q[idx*8 +: 8]);
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == '1) begin
          // Capture the finished state here so out_state only changes on completion.
          out_d   = work_d;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign out_state = out_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: directed vectors push expected results, a negedge
// monitor pops and compares on every output handshake.
module tb_sub_bytes_iter;

`ifdef SUBBYTES_PAR4_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 16;
`endif
  localparam int Ii = Lat + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  int total = 0;
  int bad = 0;
  logic [127:0] sb[$];

  logic [7:0] pin[16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                          8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
  logic [7:0] pout[16] = '{8'h63, 8'h82, 8'h93, 8'hc3, 8'h1b, 8'hfc, 8'h33, 8'hf5,
                           8'hc4, 8'hee, 8'hac, 8'hea, 8'h4b, 8'hc1, 8'h28, 8'h16};

  sub_bytes_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want no output", out_state);
      end else begin
        chk("out_state", out_state, sb.pop_front());
      end
    end
  end

  // Offer d when idle, then keep in_valid high with junk data until out_valid rises.
  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_state = d;
    sb.push_back(exp);
    @(posedge clk); #1;
    chk("busy_after_accept", 128'(busy), 128'd1);
    in_state = ~d;
    n = 0;
    while (!out_valid && n < Lat + 10) begin
      if (n == 2) chk("in_ready_run", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(n), 128'(Lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int last;
    int acc;
    int n;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_state", out_state, 128'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    send(128'h0, {16{8'h63}});
    @(posedge clk); #1;
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_out_valid", 128'(out_valid), 128'd0);
    chk("retained", out_state, {16{8'h63}});

    send(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(128'hffeeddccbbaa99887766554433221100, 128'h1628c14beaaceec4f533fc1bc3938263);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_state", out_state, 128'h1628c14beaaceec4f533fc1bc3938263);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_busy", 128'(busy), 128'd0);

    // Abort a run mid-way; in_valid and out_ready are high on the reset edge too.
    in_valid = 1'b1;
    in_state = 128'h0123456789abcdef0123456789abcdef;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("busy_mid_run", 128'(busy), 128'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_state", out_state, 128'h0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    seen = 0;
    repeat (Lat + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_partial", 128'(seen), 128'd0);

    send(128'h53, {{15{8'h63}}, 8'hed});
    @(posedge clk); #1;

    // Continuous offers with changing data: accepts must be exactly Ii cycles apart.
    in_valid = 1'b1;
    last = -1;
    acc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      in_state = {16{pin[cyc % 16]}};
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({16{pout[cyc % 16]}});
        if (last >= 0) chk("interval", 128'(cyc - last), 128'(Ii));
        last = cyc;
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_count", 128'(acc), 128'(79 / Ii + 1));

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drained", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
